// File: rtl/lcd_pkg.sv
// Shared constants and encodings for the character-LCD text controller.
package lcd_pkg;

    localparam logic [7:0] FUNCTION_SET = 8'h38;
    localparam logic [7:0] DISP_ON      = 8'h0C;
    localparam logic [7:0] ENTRY_MODE   = 8'h06;
    localparam logic [7:0] CLEAR        = 8'h01;
    localparam logic [7:0] SET_DDRAM    = 8'h80;
    localparam logic [7:0] BLANK        = 8'h20;

    typedef enum logic [1:0] {
        CMD_CHAR      = 2'b00,
        CMD_BACKSPACE = 2'b01,
        CMD_CLEAR     = 2'b10,
        CMD_NEWLINE   = 2'b11
    } cmd_e;

    typedef enum logic [3:0] {
        S_PWR, S_FUNC, S_DISP, S_ENTRY, S_CLR, S_FIN,
        S_IDLE, S_APPLY, S_ROW, S_COL, S_CUR
    } state_e;

    typedef enum logic [2:0] {
        W_IDLE, W_A, W_B, W_C, W_WAIT
    } wphase_e;

    // DDRAM start address of each display line (HD44780 layout)
    function automatic logic [7:0] row_ofs(input logic [1:0] r);
        case (r)
            2'd0:    return 8'h00;
            2'd1:    return 8'h40;
            2'd2:    return 8'h14;
            default: return 8'h54;
        endcase
    endfunction

endpackage

// File: rtl/lcd_text_ctrl_if.sv
// Keypad-decoder to LCD-controller request channel (valid/ready).
interface lcd_text_ctrl_if;
    logic [7:0] CHAR_IN;
    logic [1:0] CMD_IN;
    logic       IN_VALID;
    logic       IN_READY;

    modport master (output CHAR_IN, output CMD_IN, output IN_VALID, input IN_READY);
    modport slave  (input CHAR_IN, input CMD_IN, input IN_VALID, output IN_READY);
endinterface

// File: rtl/lcd_bus_writer.sv
// Three-phase HD44780 bus write (setup, E-high, hold) with an optional trailing wait.
module lcd_bus_writer
    import lcd_pkg::*;
#(
    parameter int STEP_CYC = 50,
    parameter int WAIT_W   = 16
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic              start,
    input  logic              rs,
    input  logic [7:0]        data,
    input  logic [WAIT_W-1:0] wait_cyc,
    output logic              ready,
    output logic              idle,
    output logic              lcd_e,
    output logic              lcd_rs,
    output logic [7:0]        lcd_data
);

    wphase_e           phase_q, phase_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d, wait_q;
    logic              step_end, finishing, load;

    assign step_end  = (cnt_q == WAIT_W'(STEP_CYC - 1));
    assign finishing = (phase_q == W_C && step_end && wait_q == '0) ||
                       (phase_q == W_WAIT && cnt_q == wait_q - WAIT_W'(1));
    // A new write may be taken in the very cycle the previous one ends, so writes run back to back
    assign ready     = (phase_q == W_IDLE) || finishing;
    assign idle      = (phase_q == W_IDLE);

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q + WAIT_W'(1);
        load    = 1'b0;
        if (start && ready) begin
            phase_d = W_A;
            cnt_d   = '0;
            load    = 1'b1;
        end else begin
            case (phase_q)
                W_IDLE: cnt_d = '0;
                W_A:    if (step_end) begin phase_d = W_B; cnt_d = '0; end
                W_B:    if (step_end) begin phase_d = W_C; cnt_d = '0; end
                W_C:    if (step_end) begin
                            phase_d = (wait_q == '0) ? W_IDLE : W_WAIT;
                            cnt_d   = '0;
                        end
                W_WAIT: if (finishing) begin phase_d = W_IDLE; cnt_d = '0; end
                default: begin phase_d = W_IDLE; cnt_d = '0; end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            phase_q  <= W_IDLE;
            cnt_q    <= '0;
            wait_q   <= '0;
            lcd_e    <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_data <= 8'h00;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            lcd_e   <= (phase_d == W_B);
            if (load) begin
                wait_q   <= wait_cyc;
                lcd_rs   <= rs;
                lcd_data <= data;
            end
        end
    end

endmodule

// File: rtl/lcd_text_ctrl.sv
// Character-LCD controller: power-up init, ROWS x COLS text buffer with cursor, full repaint per edit.
module lcd_text_ctrl
    import lcd_pkg::*;
#(
    parameter int ROWS     = 2,
    parameter int COLS     = 16,
    parameter int STEP_CYC = 50,
    parameter int PWR_WAIT = 20000,
    parameter int CLR_WAIT = 2000,
    parameter int SCROLL   = 0
) (
    input  logic              CLK,
    input  logic              RESETN,
    lcd_text_ctrl_if.slave    kp,
    output logic [7:0]        LCD_DATA,
    output logic              LCD_RS,
    output logic              LCD_RW,
    output logic              LCD_E,
    output logic              BUSY
);

    localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW     = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int WW     = $clog2(((STEP_CYC > CLR_WAIT) ? STEP_CYC : CLR_WAIT) + 1);
    localparam int PW     = $clog2(PWR_WAIT + 1);
    localparam int PREV_R = (ROWS > 1) ? ROWS - 2 : 0;
    localparam logic [RW-1:0] LAST_R = RW'(ROWS - 1);
    localparam logic [CW-1:0] LAST_C = CW'(COLS - 1);

    state_e          state_q, state_d;
    cmd_e            cmd_q;
    logic [7:0]      char_q;
    logic [7:0]      text_q [ROWS][COLS];
    logic [RW-1:0]   cur_r, rep_r;
    logic [CW-1:0]   cur_c, rep_c;
    logic [PW-1:0]   pwr_cnt;
    logic            wr_start, wr_rs, wr_ready, wr_idle, wr_take;
    logic [7:0]      wr_data;
    logic [WW-1:0]   wr_wait;
    logic            row_adv, at_last, bs_noop;

    assign wr_take = wr_start & wr_ready;
    assign row_adv = (cmd_q == CMD_NEWLINE) || (cmd_q == CMD_CHAR && cur_c == LAST_C);
    assign at_last = (cur_r == LAST_R);
    assign bs_noop = (cmd_q == CMD_BACKSPACE) && (cur_r == '0) && (cur_c == '0);

    assign kp.IN_READY = (state_q == S_IDLE);
    assign BUSY        = (state_q != S_IDLE);
    assign LCD_RW      = 1'b0;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) state_q <= S_PWR;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        wr_start = 1'b0;
        wr_rs    = 1'b0;
        wr_data  = 8'h00;
        wr_wait  = '0;
        case (state_q)
            S_PWR:   if (pwr_cnt == PW'(PWR_WAIT - 1)) state_d = S_FUNC;
            S_FUNC:  begin wr_start = 1'b1; wr_data = FUNCTION_SET; if (wr_ready) state_d = S_DISP;  end
            S_DISP:  begin wr_start = 1'b1; wr_data = DISP_ON;      if (wr_ready) state_d = S_ENTRY; end
            S_ENTRY: begin wr_start = 1'b1; wr_data = ENTRY_MODE;   if (wr_ready) state_d = S_CLR;   end
            S_CLR:   begin
                wr_start = 1'b1;
                wr_data  = CLEAR;
                wr_wait  = WW'(CLR_WAIT);
                if (wr_ready) state_d = S_FIN;
            end
            S_FIN:   if (wr_idle) state_d = S_IDLE;
            S_IDLE:  if (kp.IN_VALID) state_d = S_APPLY;
            S_APPLY: state_d = bs_noop ? S_IDLE : S_ROW;
            S_ROW:   begin
                wr_start = 1'b1;
                wr_data  = SET_DDRAM | row_ofs(2'(rep_r));
                if (wr_ready) state_d = S_COL;
            end
            S_COL:   begin
                wr_start = 1'b1;
                wr_rs    = 1'b1;
                wr_data  = text_q[rep_r][rep_c];
                if (wr_ready && rep_c == LAST_C) state_d = (rep_r == LAST_R) ? S_CUR : S_ROW;
            end
            S_CUR:   begin
                wr_start = 1'b1;
                wr_data  = SET_DDRAM | (row_ofs(2'(cur_r)) + 8'(cur_c));
                if (wr_ready) state_d = S_FIN;
            end
            default: state_d = S_PWR;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            pwr_cnt <= '0;
            rep_r   <= '0;
            rep_c   <= '0;
        end else begin
            if (state_q == S_PWR) pwr_cnt <= pwr_cnt + PW'(1);
            if (state_q == S_APPLY) begin
                rep_r <= '0;
                rep_c <= '0;
            end else if (state_q == S_COL && wr_take) begin
                if (rep_c == LAST_C) begin
                    rep_c <= '0;
                    rep_r <= rep_r + RW'(1);
                end else begin
                    rep_c <= rep_c + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (state_q == S_IDLE && kp.IN_VALID) begin
            cmd_q  <= cmd_e'(kp.CMD_IN);
            char_q <= kp.CHAR_IN;
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) text_q[r][c] <= BLANK;
            cur_r <= '0;
            cur_c <= '0;
        end else if (state_q == S_APPLY) begin
            case (cmd_q)
                CMD_CHAR: begin
                    text_q[cur_r][cur_c] <= char_q;
                    cur_c <= (cur_c == LAST_C) ? '0 : cur_c + CW'(1);
                end
                CMD_NEWLINE: cur_c <= '0;
                CMD_BACKSPACE: begin
                    if (cur_c != '0) begin
                        cur_c <= cur_c - CW'(1);
                        text_q[cur_r][cur_c - CW'(1)] <= BLANK;
                    end else if (cur_r != '0) begin
                        cur_r <= cur_r - RW'(1);
                        cur_c <= LAST_C;
                        text_q[cur_r - RW'(1)][LAST_C] <= BLANK;
                    end
                end
                CMD_CLEAR: begin
                    for (int r = 0; r < ROWS; r++)
                        for (int c = 0; c < COLS; c++) text_q[r][c] <= BLANK;
                    cur_r <= '0;
                    cur_c <= '0;
                end
                default: ;
            endcase
            if (row_adv) begin
                if (!at_last) begin
                    cur_r <= cur_r + RW'(1);
                end else if (SCROLL == 0) begin
                    cur_r <= '0;
                end else begin
                    for (int r = 0; r < ROWS - 1; r++) text_q[r] <= text_q[r + 1];
                    for (int c = 0; c < COLS; c++) text_q[LAST_R][c] <= BLANK;
                    // The character that triggered the scroll moves up with its row
                    if (ROWS > 1 && cmd_q == CMD_CHAR) text_q[PREV_R][LAST_C] <= char_q;
                end
            end
        end
    end

    lcd_bus_writer #(
        .STEP_CYC (STEP_CYC),
        .WAIT_W   (WW)
    ) u_writer (
        .CLK      (CLK),
        .RESETN   (RESETN),
        .start    (wr_start),
        .rs       (wr_rs),
        .data     (wr_data),
        .wait_cyc (wr_wait),
        .ready    (wr_ready),
        .idle     (wr_idle),
        .lcd_e    (LCD_E),
        .lcd_rs   (LCD_RS),
        .lcd_data (LCD_DATA)
    );

endmodule
